// File: rtl/comparison_pkg.sv
// Shared definitions for the registered comparator.
// Holds the predicate select encoding used by the decoder and its clients.
package comparison_pkg;

    localparam int SEL_WIDTH = 4;

    typedef enum logic [SEL_WIDTH-1:0] {
        EQUAL                          = 4'd0,
        NOT_EQUAL                      = 4'd1,
        LESS_THAN                      = 4'd2,
        LESS_THAN_UNSIGNED             = 4'd3,
        GREATER_THAN                   = 4'd4,
        GREATER_THAN_UNSIGNED          = 4'd5,
        LESS_THAN_OR_EQUAL             = 4'd6,
        LESS_THAN_OR_EQUAL_UNSIGNED    = 4'd7,
        GREATER_THAN_OR_EQUAL          = 4'd8,
        GREATER_THAN_OR_EQUAL_UNSIGNED = 4'd9
    } comparison_sel_t;

endpackage

// File: rtl/comparison_core.sv
// Combinational compare primitives: equality, signed and unsigned less-than.
// Ports: a, b operands in; eq, lt_s, lt_u single-bit results out.
module comparison_core #(
    parameter int dataWidth = 32
) (
    input  logic [dataWidth-1:0] a,
    input  logic [dataWidth-1:0] b,
    output logic                 eq,
    output logic                 lt_s,
    output logic                 lt_u
);

    always_comb begin
        eq   = (a == b);
        lt_u = (a < b);
        lt_s = ($signed(a) < $signed(b));
    end

endmodule

// File: rtl/comparison_unit.sv
// Registered comparator: decodes the predicate select over the core primitives.
// Ports: clk, reset (sync, active-low), inputA, inputB, comparisonSelect in; dataOut out.
module comparison_unit
    import comparison_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [dataWidth-1:0]   inputA,
    input  logic [dataWidth-1:0]   inputB,
    input  logic [selectWidth-1:0] comparisonSelect,
    output logic [dataWidth-1:0]   dataOut
);

    logic eq;
    logic lt_s;
    logic lt_u;
    logic pred;

    comparison_core #(
        .dataWidth(dataWidth)
    ) u_core (
        .a    (inputA),
        .b    (inputB),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    // Every predicate derives from eq and one of the two less-than flavours.
    always_comb begin
        pred = 1'b0;
        case (comparisonSelect)
            selectWidth'(EQUAL):                          pred = eq;
            selectWidth'(NOT_EQUAL):                      pred = !eq;
            selectWidth'(LESS_THAN):                      pred = lt_s;
            selectWidth'(LESS_THAN_UNSIGNED):             pred = lt_u;
            selectWidth'(GREATER_THAN):                   pred = !(lt_s | eq);
            selectWidth'(GREATER_THAN_UNSIGNED):          pred = !(lt_u | eq);
            selectWidth'(LESS_THAN_OR_EQUAL):             pred = lt_s | eq;
            selectWidth'(LESS_THAN_OR_EQUAL_UNSIGNED):    pred = lt_u | eq;
            selectWidth'(GREATER_THAN_OR_EQUAL):          pred = !lt_s;
            selectWidth'(GREATER_THAN_OR_EQUAL_UNSIGNED): pred = !lt_u;
            default:                                      pred = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dataOut <= '0;
        end else begin
            dataOut <= {{(dataWidth-1){1'b0}}, pred};
        end
    end

endmodule

// File: tb/tb_comparison_unit.sv
// Self-checking bench for comparison_unit: directed cases plus random vectors.
// Expected results come from an arithmetic reference model of the predicates.
module tb_comparison_unit;

    logic        clk;
    logic        reset;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [3:0]  comparisonSelect;
    logic [31:0] dataOut;

    int vectors;
    int miscompares;

    comparison_unit #(
        .dataWidth  (32),
        .selectWidth(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inputA          (inputA),
        .inputB          (inputB),
        .comparisonSelect(comparisonSelect),
        .dataOut         (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0] s);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        bit r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (s)
            4'd0:    r = (ua == ub);
            4'd1:    r = (ua != ub);
            4'd2:    r = (sa < sb);
            4'd3:    r = (ua < ub);
            4'd4:    r = (sa > sb);
            4'd5:    r = (ua > ub);
            4'd6:    r = (sa <= sb);
            4'd7:    r = (ua <= ub);
            4'd8:    r = (sa >= sb);
            4'd9:    r = (ua >= ub);
            default: r = 1'b0;
        endcase
        return {31'd0, r};
    endfunction

    // Apply one vector, check it one edge later, then disturb the inputs
    // between edges and check the registered output has not moved.
    task automatic cyc(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic r,
                       input string tag);
        logic [31:0] exp;
        @(negedge clk);
        inputA           = a;
        inputB           = b;
        comparisonSelect = s;
        reset            = r;
        @(posedge clk);
        #1;
        exp = r ? model(a, b, s) : 32'd0;
        check(tag, dataOut, exp);
        inputA           = ~a;
        inputB           = $urandom;
        comparisonSelect = 4'($urandom);
        #2;
        check({tag, "_hold"}, dataOut, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'h8000_0000 + 32'($urandom_range(0, 3));
            2:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
            3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b0;
        inputA           = 32'd5;
        inputB           = 32'd5;
        comparisonSelect = 4'd0;

        cyc(32'd5, 32'd5, 4'd0, 1'b0, "rst0");
        cyc(32'd5, 32'd5, 4'd0, 1'b0, "rst1");
        cyc(32'd5, 32'd5, 4'd0, 1'b1, "rst_rel");
        check("rst_rel_val", dataOut, 32'd1);

        cyc(32'h3, 32'h7, 4'd2, 1'b1, "lt_a");
        check("lt_a_val", dataOut, 32'd1);
        cyc(32'h7, 32'h7, 4'd2, 1'b1, "lt_b");
        check("lt_b_val", dataOut, 32'd0);
        cyc(32'h8000_0009, 32'h7, 4'd2, 1'b1, "lt_neg");
        check("lt_neg_val", dataOut, 32'd1);

        cyc(32'h8000_0003, 32'h7, 4'd5, 1'b1, "gtu_a");
        cyc(32'h7, 32'h7, 4'd5, 1'b1, "gtu_b");
        cyc(32'h9, 32'h7, 4'd5, 1'b1, "gtu_c");

        cyc(32'h8000_0003, 32'h7, 4'd8, 1'b1, "ge_a");
        check("ge_a_val", dataOut, 32'd0);
        cyc(32'h7, 32'h7, 4'd8, 1'b1, "ge_b");
        cyc(32'h9, 32'h7, 4'd8, 1'b1, "ge_c");
        cyc(32'h8000_0003, 32'h7, 4'd9, 1'b1, "geu_a");
        check("geu_a_val", dataOut, 32'd1);
        cyc(32'h7, 32'h7, 4'd9, 1'b1, "geu_b");
        cyc(32'h9, 32'h7, 4'd9, 1'b1, "geu_c");

        cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b1, "eq_ones");
        check("eq_ones_val", dataOut, 32'd1);
        cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b1, "ne_ones");

        for (int s = 0; s < 16; s++) begin
            cyc(32'd3, 32'd3, 4'(s), 1'b1, $sformatf("sel%0d_eqops", s));
            cyc(32'h8000_0000, 32'd1, 4'(s), 1'b1,
                $sformatf("sel%0d_neg", s));
        end

        // Mid-stream reset drops a result that would otherwise be 1.
        cyc(32'd1, 32'd2, 4'd3, 1'b1, "pre_rst");
        cyc(32'd1, 32'd2, 4'd3, 1'b0, "mid_rst");

        for (int i = 0; i < 400; i++) begin
            a = pick();
            b = ($urandom_range(0, 4) == 0) ? a : pick();
            cyc(a, b, 4'($urandom), ($urandom_range(0, 19) != 0),
                $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comparison_unit.md
# comparison_unit

Registered integer comparator for the RISC-V datapath. It compares two operands under a selectable predicate and returns the 1-bit result zero-extended to the full data width. It sits beside the ALU and feeds the SLT/SLTU writeback path and the branch-decision logic.

## Interface

- dataWidth, 32, operand and result width in bits (minimum 2).
- selectWidth, 4, width of the predicate select bus.
- clk  input  1  rising-edge clock; the single clock domain.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- inputA  input  dataWidth  left-hand operand.
- inputB  input  dataWidth  right-hand operand.
- comparisonSelect  input  selectWidth  predicate code, from the shared enum.
- dataOut  output  dataWidth  registered result; bit 0 is the predicate, all other bits are 0.

## Operation

- Predicate codes, evaluated as "A op B":
  - 0 EQUAL: A == B.
  - 1 NOT_EQUAL: A != B.
  - 2 LESS_THAN: signed A < B.
  - 3 LESS_THAN_UNSIGNED: unsigned A < B.
  - 4 GREATER_THAN: signed A > B.
  - 5 GREATER_THAN_UNSIGNED: unsigned A > B.
  - 6 LESS_THAN_OR_EQUAL: signed A <= B.
  - 7 LESS_THAN_OR_EQUAL_UNSIGNED: unsigned A <= B.
  - 8 GREATER_THAN_OR_EQUAL: signed A >= B.
  - 9 GREATER_THAN_OR_EQUAL_UNSIGNED: unsigned A >= B.
  - 10–15 reserved: result 0.
- Signed predicates use two's complement; the MSB is the sign.
- Unsigned predicates treat operands as plain magnitudes.
- Core primitives: eq, lt_s, lt_u. All other predicates derive from these:
  - gt = !(lt | eq).
  - le = lt | eq.
  - ge = !lt.
- Result is zero-extended: dataOut[dataWidth-1:1] = 0 always.
- Purely functional: no state beyond the output register, no overflow or exception flags.

## Timing

- Latency is 1 cycle. Operands and select present before rising edge N appear on dataOut after edge N and hold until edge N+1.
- Throughput is one comparison per cycle; there is no handshake and no stall.
- Reset:
  - reset == 0 at a rising edge forces dataOut to 0, regardless of the inputs.
  - Reset has priority over a new comparison.
  - On the first edge with reset == 1, dataOut loads the current comparison.
  - Reset asserted mid-stream discards the in-flight result.
- Between edges, dataOut does not change with input changes.
- The comparison logic is combinational, inputs to register D. It must close timing at the target clock for dataWidth = 32.

## Structure

- Package `comparison_pkg`: typedef enum `comparison_sel_t` [selectWidth-1:0] holding codes 0–9 above, with names EQUAL … GREATER_THAN_OR_EQUAL_UNSIGNED.
- Sub-module `comparison_core`: combinational, parameterised by dataWidth. Takes the operands and produces eq, lt_s, lt_u.
- Top module:
  - instantiates the core;
  - decodes the select into the predicate bit with a full case (default 0);
  - holds the reset-able output register.

## Test plan

1. Reset: hold reset low 2 cycles with inputA = inputB = 5, EQUAL → dataOut = 0x00000000. Release → next cycle dataOut = 0x00000001.
2. LESS_THAN, one cycle apart:
   - (0x3, 0x7) → 1.
   - (0x7, 0x7) → 0.
   - (0x80000009, 0x7) → 1 (negative less than positive).
3. GREATER_THAN_UNSIGNED: (0x80000003, 0x7) → 1; (0x7, 0x7) → 0; (0x9, 0x7) → 1.
4. GREATER_THAN_OR_EQUAL: (0x80000003, 0x7) → 0; (0x7, 0x7) → 1; (0x9, 0x7) → 1. Repeat with GREATER_THAN_OR_EQUAL_UNSIGNED → 1, 1, 1.
5. EQUAL / NOT_EQUAL and reserved codes:
   - (0xFFFFFFFF, 0xFFFFFFFF) EQUAL → 1, NOT_EQUAL → 0.
   - Any select 10–15 → 0.
6. Latency and holding:
   - Change the inputs between edges → dataOut is unchanged until the next edge.
   - Back-to-back selects on consecutive cycles each yield their result exactly one cycle later.
   - Upper 31 bits of dataOut are always 0.
